// File: rtl/pc_gen_pkg.sv
// Shared types for the fetch-stage program-counter generator:
// FSM state encoding and the redirect-kind encoding.
package pc_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      RD_NONE   = 2'd0,
      RD_BRANCH = 2'd1,
      RD_EXC    = 2'd2
   } redir_e;

endpackage

// File: rtl/pc_gen_ras.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry; a pop on an empty stack does nothing; pop+push together
// replace the top entry in place.
module pc_gen_ras #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [ADDR_W-1:0] push_data_i,
   output logic [ADDR_W-1:0] top_o,
   output logic              empty_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wp_q, wp_d, top_idx, wr_idx;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
      return (p == '0) ? PW'(DEPTH - 1) : p - PW'(1);
   endfunction

   // wp_q is the next free slot; the top lives one slot below it
   assign top_idx = ptr_dec(wp_q);
   assign top_o   = mem_q[top_idx];
   assign empty_o = (cnt_q == '0);
   assign do_pop  = pop_i && !empty_o;

   // Pointer/count update and choice of the write slot
   always_comb begin
      wp_d   = wp_q;
      cnt_d  = cnt_q;
      wr_idx = wp_q;
      if (do_pop && push_i) begin
         wr_idx = top_idx;
      end else if (do_pop) begin
         wp_d  = top_idx;
         cnt_d = cnt_q - CW'(1);
      end else if (push_i) begin
         wp_d  = ptr_inc(wp_q);
         cnt_d = (cnt_q == CW'(DEPTH)) ? cnt_q : cnt_q + CW'(1);
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         cnt_q <= cnt_d;
      end
   end

   // Entry storage needs no reset: occupancy guards every read
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_idx] <= push_data_i;
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator with IDLE/RUN/HALT control,
// prioritised redirects and a latch for redirects arriving under stall.
// Optional return-address stack enabled by defining PC_GEN_RAS_EN.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter int unsigned       INC       = 4,
   parameter bit                SATURATE  = 1'b1,
   parameter int unsigned       RAS_DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              inited_i,
   input  logic              stall_i,
   input  logic              exc_flag_i,
   input  logic [ADDR_W-1:0] exc_addr_i,
   input  logic              branch_flag_i,
   input  logic [ADDR_W-1:0] branch_addr_i,
   input  logic              halt_req_i,
   input  logic              call_flag_i,
   input  logic              ret_flag_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              pc_valid_o,
   output logic              redirect_pending_o,
   output logic              halted_o,
   output logic              ras_empty_o
);

   // All-ones with the low log2(INC) bits clear: alignment mask and
   // also the highest aligned address, where saturation parks the PC.
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INC - 1));

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   redir_e            pk_q, pk_d;
   logic [ADDR_W-1:0] pa_q, pa_d;

   logic [ADDR_W:0]   seq_sum;
   logic [ADDR_W-1:0] seq_pc, tgt;
   logic              take, adv, ret_ok, ras_empty;
   logic [ADDR_W-1:0] ras_top;

   // Sequential successor with carry detection for the end-of-space policy
   always_comb begin
      seq_sum = {1'b0, pc_q} + (ADDR_W + 1)'(INC);
      seq_pc  = seq_sum[ADDR_W-1:0];
      if (seq_sum[ADDR_W]) seq_pc = SATURATE ? ALIGN_MASK : '0;
   end

`ifdef PC_GEN_RAS_EN
   pc_gen_ras #(
      .ADDR_W (ADDR_W),
      .DEPTH  (RAS_DEPTH)
   ) u_ras (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (adv && call_flag_i),
      .pop_i       (adv && ret_flag_i),
      .push_data_i (seq_sum[ADDR_W-1:0]),
      .top_o       (ras_top),
      .empty_o     (ras_empty)
   );
   assign ret_ok = ret_flag_i && !ras_empty;
`else
   logic unused_ras;
   assign ras_empty  = 1'b1;
   assign ras_top    = '0;
   assign ret_ok     = 1'b0;
   assign unused_ras = ^{call_flag_i, ret_flag_i, adv, RAS_DEPTH};
`endif

   // Next-state, next-PC and pending-redirect selection
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pk_d    = pk_q;
      pa_d    = pa_q;
      adv     = 1'b0;
      take    = 1'b1;
      tgt     = '0;
      case (state_q)
         IDLE: begin
            pc_d = RESET_VEC;
            pk_d = RD_NONE;
            if (inited_i) state_d = RUN;
         end
         RUN: begin
            if (!inited_i) begin
               state_d = IDLE;
               pc_d    = RESET_VEC;
               pk_d    = RD_NONE;
            end else if (stall_i) begin
               // latch only if not lower priority than what is waiting
               if (exc_flag_i) begin
                  pk_d = RD_EXC;
                  pa_d = exc_addr_i;
               end else if (branch_flag_i && pk_q != RD_EXC) begin
                  pk_d = RD_BRANCH;
                  pa_d = branch_addr_i;
               end
            end else begin
               adv  = 1'b1;
               pk_d = RD_NONE;
               if (exc_flag_i)               tgt = exc_addr_i;
               else if (pk_q == RD_EXC)      tgt = pa_q;
               else if (branch_flag_i)       tgt = branch_addr_i;
               else if (pk_q == RD_BRANCH)   tgt = pa_q;
               else if (ret_ok)              tgt = ras_top;
               else                          take = 1'b0;
               // a redirect wins over halt; halt is retried next cycle
               if (take)            pc_d    = tgt & ALIGN_MASK;
               else if (halt_req_i) state_d = HALT;
               else                 pc_d    = seq_pc;
            end
         end
         HALT: begin
            if (!inited_i) begin
               state_d = IDLE;
               pc_d    = RESET_VEC;
            end else if (exc_flag_i) begin
               state_d = RUN;
               pc_d    = exc_addr_i & ALIGN_MASK;
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = RESET_VEC;
            pk_d    = RD_NONE;
         end
      endcase
   end

   // State, PC and pending-redirect registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         pc_q    <= RESET_VEC;
         pk_q    <= RD_NONE;
         pa_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pk_q    <= pk_d;
         pa_q    <= pa_d;
      end
   end

   assign pc_o               = pc_q;
   assign pc_valid_o         = (state_q == RUN) && !stall_i;
   assign redirect_pending_o = (pk_q != RD_NONE);
   assign halted_o           = (state_q == HALT);
   assign ras_empty_o        = ras_empty;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: two instances (saturating and wrapping, 16-bit PC,
// RAS depth 2) share one randomised stimulus stream and are compared every
// cycle against a queue-based behavioural model of the fetch PC rules.
module tb_pc_gen;

   localparam int unsigned W   = 16;
   localparam int unsigned INC = 4;
   localparam int unsigned RV  = 0;
   localparam int unsigned DEP = 2;
   localparam int unsigned LIM = 1 << W;
`ifdef PC_GEN_RAS_EN
   localparam bit RAS_ON = 1'b1;
`else
   localparam bit RAS_ON = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst, inited, stall, exc, br, halt, call, ret;
   logic [W-1:0] exc_addr, br_addr;

   logic [W-1:0] pc_w [2];
   logic         valid_w [2], pend_w [2], halted_w [2], rempty_w [2];

   int n_vec = 0;
   int n_err = 0;

   // model state: 0 idle, 1 run, 2 halt; pending kind 0 none, 1 branch, 2 exc
   int unsigned m_st [2], m_pc [2], m_pk [2], m_pa [2];
   int unsigned m_ras [2][$];
   string       nm [2] = '{"sat", "wrap"};

   always #5 clk = ~clk;

   pc_gen #(.ADDR_W(W), .RESET_VEC(16'h0), .INC(INC), .SATURATE(1'b1),
            .RAS_DEPTH(DEP)) u_sat (
      .clk_i(clk), .rst_i(rst), .inited_i(inited), .stall_i(stall),
      .exc_flag_i(exc), .exc_addr_i(exc_addr), .branch_flag_i(br),
      .branch_addr_i(br_addr), .halt_req_i(halt), .call_flag_i(call),
      .ret_flag_i(ret), .pc_o(pc_w[0]), .pc_valid_o(valid_w[0]),
      .redirect_pending_o(pend_w[0]), .halted_o(halted_w[0]),
      .ras_empty_o(rempty_w[0]));

   pc_gen #(.ADDR_W(W), .RESET_VEC(16'h0), .INC(INC), .SATURATE(1'b0),
            .RAS_DEPTH(DEP)) u_wrap (
      .clk_i(clk), .rst_i(rst), .inited_i(inited), .stall_i(stall),
      .exc_flag_i(exc), .exc_addr_i(exc_addr), .branch_flag_i(br),
      .branch_addr_i(br_addr), .halt_req_i(halt), .call_flag_i(call),
      .ret_flag_i(ret), .pc_o(pc_w[1]), .pc_valid_o(valid_w[1]),
      .redirect_pending_o(pend_w[1]), .halted_o(halted_w[1]),
      .ras_empty_o(rempty_w[1]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int unsigned align(input int unsigned a);
      return a - (a % INC);
   endfunction

   // Behavioural reference: one clock edge for instance k (k=0 saturates)
   task automatic model_step(input int k);
      int unsigned tgt, nx;
      bit          take, ret_ok;
      if (rst) begin
         m_st[k] = 0; m_pc[k] = RV; m_pk[k] = 0; m_pa[k] = 0;
         m_ras[k].delete();
         return;
      end
      case (m_st[k])
         0: begin
            m_pc[k] = RV; m_pk[k] = 0;
            if (inited) m_st[k] = 1;
         end
         1: begin
            if (!inited) begin
               m_st[k] = 0; m_pc[k] = RV; m_pk[k] = 0;
            end else if (stall) begin
               if (exc) begin
                  m_pk[k] = 2; m_pa[k] = exc_addr;
               end else if (br && m_pk[k] != 2) begin
                  m_pk[k] = 1; m_pa[k] = br_addr;
               end
            end else begin
               ret_ok = RAS_ON && ret && (m_ras[k].size() > 0);
               take = 1'b1; tgt = 0;
               if (exc)               tgt = exc_addr;
               else if (m_pk[k] == 2) tgt = m_pa[k];
               else if (br)           tgt = br_addr;
               else if (m_pk[k] == 1) tgt = m_pa[k];
               else if (ret_ok)       tgt = m_ras[k][$];
               else                   take = 1'b0;
               m_pk[k] = 0;
               if (RAS_ON) begin
                  if (ret_ok) void'(m_ras[k].pop_back());
                  if (call) begin
                     m_ras[k].push_back((m_pc[k] + INC) % LIM);
                     if (m_ras[k].size() > DEP) void'(m_ras[k].pop_front());
                  end
               end
               if (take) m_pc[k] = align(tgt);
               else if (halt) m_st[k] = 2;
               else begin
                  nx = m_pc[k] + INC;
                  if (nx >= LIM) nx = (k == 0) ? LIM - INC : 0;
                  m_pc[k] = nx;
               end
            end
         end
         default: begin
            if (!inited) begin
               m_st[k] = 0; m_pc[k] = RV;
            end else if (exc) begin
               m_st[k] = 1; m_pc[k] = align(exc_addr);
            end
         end
      endcase
   endtask

   // compare both instances at the falling edge, then advance the model
   task automatic cycle();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s.pc", nm[k]),     32'(pc_w[k]),    m_pc[k]);
         chk($sformatf("%s.valid", nm[k]),  32'(valid_w[k]), 32'(m_st[k] == 1 && !stall));
         chk($sformatf("%s.pend", nm[k]),   32'(pend_w[k]),  32'(m_pk[k] != 0));
         chk($sformatf("%s.halted", nm[k]), 32'(halted_w[k]), 32'(m_st[k] == 2));
         chk($sformatf("%s.rempty", nm[k]), 32'(rempty_w[k]), 32'(m_ras[k].size() == 0));
      end
      for (int k = 0; k < 2; k++) model_step(k);
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      rst = 0; stall = 0; exc = 0; br = 0; halt = 0; call = 0; ret = 0;
      exc_addr = '0; br_addr = '0;
   endtask

   task automatic jump(input logic [W-1:0] a);
      br = 1; br_addr = a; cycle(); br = 0;
   endtask

   initial begin
      quiet();
      rst = 1; inited = 0;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) model_step(k);
      cycle();                              // reset values
      rst = 0; inited = 1;
      repeat (4) cycle();                   // boot: idle, then 0, 4, 8

      // stalled branch then exc: exc wins once the stall drops
      stall = 1; br = 1; br_addr = 16'h0100; cycle();
      br = 0; exc = 1; exc_addr = 16'h0080; cycle();
      exc = 0; cycle();
      stall = 0; repeat (2) cycle();

      // end of address space: saturate vs wrap
      jump(16'hFFF8); repeat (3) cycle();

      // halt at 0x20, ignored noise, exc resumes at 0x40
      jump(16'h0020);
      halt = 1; cycle(); halt = 0;
      br = 1; br_addr = 16'h0300; call = 1; repeat (5) cycle();
      br = 0; call = 0;
      exc = 1; exc_addr = 16'h0040; cycle(); exc = 0; cycle();

      // re-init with a pending redirect
      jump(16'h003C);
      stall = 1; br = 1; br_addr = 16'h0200; cycle(); br = 0;
      stall = 0; inited = 0; cycle(); cycle();
      inited = 1; repeat (2) cycle();

      // calls at 0x10, 0x20, 0x30 then three rets
      jump(16'h0010);
      call = 1; br = 1; br_addr = 16'h0020; cycle();
      br_addr = 16'h0030; cycle();
      br_addr = 16'h0100; cycle();
      call = 0; br = 0;
      ret = 1; repeat (3) cycle(); ret = 0; cycle();

      // randomised traffic, sometimes aimed at the top of the space
      for (int i = 0; i < 600; i++) begin
         rst      = ($urandom_range(0, 199) == 0);
         inited   = ($urandom_range(0, 39) != 0);
         stall    = ($urandom_range(0, 3) == 0);
         exc      = ($urandom_range(0, 15) == 0);
         br       = ($urandom_range(0, 7) == 0);
         halt     = ($urandom_range(0, 19) == 0);
         call     = ($urandom_range(0, 7) == 0);
         ret      = ($urandom_range(0, 7) == 0);
         exc_addr = W'($urandom_range(0, LIM - 1));
         br_addr  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(LIM - 16, LIM - 1))
                                                : W'($urandom_range(0, LIM - 1));
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the fetch stage.
- Successor to the single-width PC register. Generalised in address width, reset vector, increment and end-of-space policy.
- Adds prioritised redirects (exception over branch), a latch that holds redirects that arrive while stalled, and an explicit IDLE/RUN/HALT state machine.
- Drives the instruction-memory address and the valid qualifier for the IF stage.

Parameters:
- ADDR_W, 32, PC width in bits.
- RESET_VEC, 0, PC value in IDLE and after reset. Must be INC-aligned.
- INC, 4, sequential increment in bytes. Power of two.
- SATURATE, 1, end-of-space policy. 1: PC holds at the top aligned address. 0: PC wraps modulo 2^ADDR_W.
- RAS_DEPTH, 4, return-stack entries. Used only with PC_GEN_RAS_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- inited  in  1  memory/boot initialisation complete. Low forces IDLE.
- stall  in  1  hold the PC; redirects are latched, not applied.
- exc_flag  in  1  exception redirect. Highest priority.
- exc_addr  in  ADDR_W  exception target.
- branch_flag  in  1  branch/jump redirect.
- branch_addr  in  ADDR_W  branch target.
- halt_req  in  1  stop fetching.
- call_flag  in  1  push pc+INC onto the RAS. Ignored without the feature.
- ret_flag  in  1  redirect to the RAS top. Ignored without the feature.
- pc  out  ADDR_W  current fetch address.
- pc_valid  out  1  high only in RUN with stall low.
- redirect_pending  out  1  a latched redirect is waiting.
- halted  out  1  state is HALT.
- ras_empty  out  1  RAS holds no entries. Constant 1 without the feature.

Behaviour:
- Reset values (rst=1 at posedge):
  - state=IDLE, pc=RESET_VEC.
  - pending cleared, pc_valid=0, redirect_pending=0, halted=0.
  - RAS pointer/count=0, ras_empty=1.
- All outputs are registered except pc_valid, which is decoded from state and stall.
- States:
  - IDLE: pc=RESET_VEC. Go to RUN when inited=1; first fetch of RESET_VEC happens the following cycle.
  - RUN: inited=0 → IDLE, pc=RESET_VEC, pending cleared. Otherwise halt_req=1 with no redirect → HALT, pc held.
  - HALT: pc held, halted=1. exc_flag=1 → RUN with pc=exc_addr. inited=0 → IDLE. Everything else is ignored.
- Next-PC selection in RUN with stall=0 (one-cycle latency), highest priority first:
  - new exc;
  - pending exc;
  - new branch;
  - pending branch;
  - ret (feature on, RAS not empty);
  - sequential.
- Sequential step is pc+INC, computed at ADDR_W+1 bits.
  - Carry out with SATURATE=1: pc holds at 2^ADDR_W−INC.
  - Carry out with SATURATE=0: pc wraps to 0.
- Stall=1:
  - pc holds.
  - A redirect presented this cycle is latched if its priority is ≥ the pending one: exc replaces anything; branch replaces only a pending branch.
  - redirect_pending rises the next cycle.
  - The pending redirect is consumed (cleared) on the first unstalled RUN cycle.
- Applied redirect addresses are forced aligned: low log2(INC) bits cleared.
- halt_req and a redirect in the same cycle: the redirect is applied, state stays RUN, and halt is re-evaluated the next cycle.

Optional Feature:
- Macro: PC_GEN_RAS_EN.
- Defined:
  - Circular return stack of RAS_DEPTH×ADDR_W entries.
  - call_flag pushes pc+INC. When full, the oldest entry is overwritten; count saturates at RAS_DEPTH.
  - ret_flag pops and redirects to the top entry at ret priority.
  - ret on an empty stack is a no-op with a sequential step.
  - call and ret in the same cycle: pop then push, so the top is replaced.
  - Push/pop happen only on unstalled RUN cycles.
- Undefined: call_flag and ret_flag are ignored, ras_empty is tied to 1, no storage is instantiated.

Decomposition:
- Package pc_gen_pkg: state encoding (IDLE=2'd0, RUN=2'd1, HALT=2'd2) and the redirect-kind encoding (NONE, BRANCH, EXC).
- One natural sub-module: pc_gen_ras, the circular stack with push/pop/top/empty. Instantiated only under PC_GEN_RAS_EN.

Test Plan:
- Boot: rst=1, then inited=1 → pc=0 in IDLE, pc_valid rises the cycle after, pc sequence 0, 4, 8.
- Stalled redirect: stall=1 with branch_flag, branch_addr=0x100, then exc_flag, exc_addr=0x80 → redirect_pending=1; after the stall drops, pc=0x80 and pending is cleared.
- Limit: ADDR_W=8, pc=0xFC → SATURATE=1 holds 0xFC; SATURATE=0 gives 0x00.
- Halt: halt_req at pc=0x20 → halted=1, pc stays 0x20 for 5 cycles; exc_addr=0x40 → RUN with pc=0x40.
- Re-init: inited dropped mid-run at pc=0x3C → IDLE, pc=RESET_VEC, pending cleared.
- RAS (macro defined, depth 2): calls at pc 0x10, 0x20, 0x30, then three rets → pc 0x34, 0x24, then a sequential step with ras_empty=1.
